// File: rtl/hazard_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Purpose  : Shared types, constants and compare helpers for the regfile
//            write-path hazard/forwarding controller.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    localparam int               REG_W    = 5;
    localparam logic [REG_W-1:0] ZERO_REG = 5'd31;
    localparam int               CNT_W    = 16;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_t;

    typedef struct packed {
        logic             valid;
        logic             reg_wrt;
        logic             is_load;
        logic [REG_W-1:0] rd;
    } track_entry_t;

    localparam track_entry_t BUBBLE = '{valid: 1'b0, reg_wrt: 1'b0, is_load: 1'b0, rd: '0};

    // A slot produces a value for src only if it really writes a non-XZR register.
    function automatic logic entry_match(input track_entry_t e,
                                         input logic [REG_W-1:0] src,
                                         input logic [REG_W-1:0] zero_reg);
        return e.valid & e.reg_wrt & (e.rd == src) & (src != zero_reg);
    endfunction

    // Youngest producer wins; a load still in EX is left to the load-use stall.
    function automatic fwd_sel_t fwd_select(input logic             use_src,
                                            input logic [REG_W-1:0] src,
                                            input track_entry_t     s0,
                                            input track_entry_t     s1,
                                            input track_entry_t     s2,
                                            input logic [REG_W-1:0] zero_reg);
        fwd_sel_t w_sel;
        w_sel = FWD_RF;
        if (!use_src)
            w_sel = FWD_RF;
        else if (entry_match(s0, src, zero_reg))
            w_sel = s0.is_load ? FWD_RF : FWD_EX;
        else if (entry_match(s1, src, zero_reg))
            w_sel = FWD_MEM;
        else if (entry_match(s2, src, zero_reg))
            w_sel = FWD_WB;
        return w_sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_forward_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hazard_forward_ctrl_if
// Purpose  : Issue-side request and regfile/forwarding response bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_forward_ctrl_if #(
    parameter int CNT_W = hazard_pkg::CNT_W
);
    import hazard_pkg::*;

    logic             IssueValid;
    logic             IssueRegWrt;
    logic             IssueIsLoad;
    logic [REG_W-1:0] IssueRd;
    logic [REG_W-1:0] Rn;
    logic [REG_W-1:0] Rm;
    logic             UseRn;
    logic             UseRm;
    logic             Flush;

    logic             Stall;
    fwd_sel_t         FwdA;
    fwd_sel_t         FwdB;
    logic             WbRegWrt;
    logic [REG_W-1:0] WbRd;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output IssueValid, IssueRegWrt, IssueIsLoad, IssueRd, Rn, Rm, UseRn, UseRm, Flush,
        input  Stall, FwdA, FwdB, WbRegWrt, WbRd, StallCount
    );

    modport slave (
        input  IssueValid, IssueRegWrt, IssueIsLoad, IssueRd, Rn, Rm, UseRn, UseRm, Flush,
        output Stall, FwdA, FwdB, WbRegWrt, WbRd, StallCount
    );

endinterface
`default_nettype wire

// File: rtl/hazard_track_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hazard_track_stage
// Purpose  : One pipeline tracking slot; kill loads a bubble instead of i_d.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_track_stage
    import hazard_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   reset,
    input  wire logic   i_kill,
    input  track_entry_t i_d,
    output track_entry_t o_q
);

    track_entry_t r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_q <= BUBBLE;
        else if (i_kill)
            r_q <= BUBBLE;
        else
            r_q <= i_d;
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/hazard_forward_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hazard_forward_ctrl
// Purpose  : Tracks in-flight destinations through EX/MEM/WB, drives the
//            regfile write port, forwarding selects and the load-use stall.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter logic [REG_W-1:0] ZERO_REG = hazard_pkg::ZERO_REG,
    parameter int               CNT_W    = hazard_pkg::CNT_W
) (
    input wire logic             clk,
    input wire logic             reset,
    hazard_forward_ctrl_if.slave bus
);

    localparam int C_NUM_SLOTS = 3;

    track_entry_t [C_NUM_SLOTS-1:0] w_d;
    track_entry_t [C_NUM_SLOTS-1:0] w_q;
    logic         [C_NUM_SLOTS-1:0] w_kill;
    track_entry_t                   w_issue;
    logic                           w_stall;
    logic                           w_accept;
    logic         [CNT_W-1:0]       r_stall_count;

    assign w_issue = '{valid: 1'b1, reg_wrt: bus.IssueRegWrt,
                       is_load: bus.IssueIsLoad, rd: bus.IssueRd};

    // Only a load sitting in EX can't be forwarded in time.
    assign w_stall = bus.IssueValid & ~bus.Flush & w_q[0].is_load &
                     ((bus.UseRn & entry_match(w_q[0], bus.Rn, ZERO_REG)) |
                      (bus.UseRm & entry_match(w_q[0], bus.Rm, ZERO_REG)));

    assign w_accept = bus.IssueValid & ~w_stall & ~bus.Flush;

    // Slot 0 = EX, 1 = MEM, 2 = WB. Flush kills issue and the EX occupant.
    assign w_d[0]    = w_issue;
    assign w_d[1]    = w_q[0];
    assign w_d[2]    = w_q[1];
    assign w_kill[0] = ~w_accept;
    assign w_kill[1] = bus.Flush;
    assign w_kill[2] = 1'b0;

    generate
        for (genvar i = 0; i < C_NUM_SLOTS; i++) begin : g_stage
            hazard_track_stage u_stage (
                .clk    (clk),
                .reset  (reset),
                .i_kill (w_kill[i]),
                .i_d    (w_d[i]),
                .o_q    (w_q[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_stall_count <= '0;
        else if (w_stall && (r_stall_count != {CNT_W{1'b1}}))
            r_stall_count <= r_stall_count + 1'b1;
    end

    assign bus.Stall      = w_stall;
    assign bus.FwdA       = fwd_select(bus.UseRn, bus.Rn, w_q[0], w_q[1], w_q[2], ZERO_REG);
    assign bus.FwdB       = fwd_select(bus.UseRm, bus.Rm, w_q[0], w_q[1], w_q[2], ZERO_REG);
    assign bus.WbRegWrt   = w_q[2].valid & w_q[2].reg_wrt & (w_q[2].rd != ZERO_REG);
    assign bus.WbRd       = w_q[2].rd;
    assign bus.StallCount = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hazard_forward_ctrl
// Purpose  : Self-checking bench; expected regfile writes are queued at issue
//            and retired by a write-back monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_ctrl;
    import hazard_pkg::*;

    typedef struct {
        logic [4:0] rd;
        int         due;
    } wb_exp_t;

    logic    clk = 1'b0;
    logic    reset;
    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    int      exp_stall_cnt = 0;
    wb_exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hazard_forward_ctrl_if bus ();

    hazard_forward_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Write-back monitor: every cycle either the head write is due or the port is idle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due < cyc) begin
            checks++; errors++;
            $display("FAIL wb_missed: write to X%0d due at cycle %0d never checked", sb[0].rd, sb[0].due);
            void'(sb.pop_front());
        end
        checks++;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            if (bus.WbRegWrt !== 1'b1 || bus.WbRd !== sb[0].rd) begin
                errors++;
                $display("FAIL wb_write cycle %0d: got WbRegWrt=%b WbRd=%0d, expected WbRegWrt=1 WbRd=%0d",
                         cyc, bus.WbRegWrt, bus.WbRd, sb[0].rd);
            end
            void'(sb.pop_front());
        end else if (bus.WbRegWrt !== 1'b0) begin
            errors++;
            $display("FAIL wb_idle cycle %0d: got WbRegWrt=%b WbRd=%0d, expected WbRegWrt=0",
                     cyc, bus.WbRegWrt, bus.WbRd);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic drive(input logic v, input logic rw, input logic ld, input logic [4:0] rd,
                         input logic [4:0] rn, input logic [4:0] rm,
                         input logic urn, input logic urm, input logic fl);
        bus.IssueValid  = v;
        bus.IssueRegWrt = rw;
        bus.IssueIsLoad = ld;
        bus.IssueRd     = rd;
        bus.Rn          = rn;
        bus.Rm          = rm;
        bus.UseRn       = urn;
        bus.UseRm       = urm;
        bus.Flush       = fl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wb(input logic [4:0] rd);
        wb_exp_t e;
        e.rd  = rd;
        e.due = cyc + 3;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        #1 reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
        repeat (2) step();
        @(negedge clk);
        checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.Stall); end
        checks++; if (bus.FwdA !== 2'b00) begin errors++; $display("FAIL reset_fwda: got %b expected 00", bus.FwdA); end
        checks++; if (bus.FwdB !== 2'b00) begin errors++; $display("FAIL reset_fwdb: got %b expected 00", bus.FwdB); end
        checks++; if (bus.WbRegWrt !== 1'b0) begin errors++; $display("FAIL reset_wbregwrt: got %b expected 0", bus.WbRegWrt); end
        checks++; if (bus.WbRd !== 5'd0) begin errors++; $display("FAIL reset_wbrd: got %0d expected 0", bus.WbRd); end
        checks++; if (bus.StallCount !== 16'd0) begin errors++; $display("FAIL reset_stallcount: got %0d expected 0", bus.StallCount); end
        step();
        idle();
        reset = 1'b1;
        repeat (3) begin
            step();
            @(negedge clk);
            checks++; if (bus.WbRegWrt !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got WbRegWrt=%b expected 0", bus.WbRegWrt); end
        end
        step();
    endtask

    task automatic test_forward_chain();
        logic [1:0] exp_fwd [4];
        exp_fwd = '{2'b01, 2'b10, 2'b11, 2'b00};
        drive(1'b1, 1'b1, 1'b0, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        push_wb(5'd1);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            checks++; if (bus.FwdA !== exp_fwd[i]) begin errors++; $display("FAIL fwd_chain_+%0d: got FwdA=%b expected %b", i + 1, bus.FwdA, exp_fwd[i]); end
            checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL fwd_chain_stall_+%0d: got %b expected 0", i + 1, bus.Stall); end
            step();
        end
        idle();
        repeat (3) step();
    endtask

    task automatic test_load_use();
        drive(1'b1, 1'b1, 1'b1, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        push_wb(5'd2);
        step();
        drive(1'b1, 1'b1, 1'b0, 5'd4, 5'd0, 5'd2, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (bus.Stall !== 1'b1) begin errors++; $display("FAIL load_use_stall: got %b expected 1", bus.Stall); end
        checks++; if (bus.FwdB !== 2'b00) begin errors++; $display("FAIL load_use_fwdb_ex: got %b expected 00", bus.FwdB); end
        exp_stall_cnt++;
        step();
        @(negedge clk);
        checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL load_use_release: got Stall=%b expected 0", bus.Stall); end
        checks++; if (bus.FwdB !== 2'b10) begin errors++; $display("FAIL load_use_fwdb_mem: got %b expected 10", bus.FwdB); end
        checks++; if (bus.StallCount !== 16'(exp_stall_cnt)) begin errors++; $display("FAIL load_use_count: got %0d expected %0d", bus.StallCount, exp_stall_cnt); end
        push_wb(5'd4);
        step();
        idle();
        repeat (4) step();
        checks++; if (bus.StallCount !== 16'(exp_stall_cnt)) begin errors++; $display("FAIL load_use_count_hold: got %0d expected %0d", bus.StallCount, exp_stall_cnt); end
    endtask

    task automatic test_zero_reg();
        drive(1'b1, 1'b1, 1'b1, 5'd31, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd31, 5'd31, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL xzr_stall: got %b expected 0", bus.Stall); end
        checks++; if (bus.FwdA !== 2'b00) begin errors++; $display("FAIL xzr_fwda_ex: got %b expected 00", bus.FwdA); end
        step();
        @(negedge clk);
        checks++; if (bus.FwdB !== 2'b00) begin errors++; $display("FAIL xzr_fwdb_mem: got %b expected 00", bus.FwdB); end
        step();
        idle();
        repeat (4) step();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        push_wb(5'd3);
        step();
        drive(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        push_wb(5'd3);
        step();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (bus.FwdA !== 2'b01) begin errors++; $display("FAIL b2b_fwda: got %b expected 01", bus.FwdA); end
        checks++; if (bus.FwdB !== 2'b01) begin errors++; $display("FAIL b2b_fwdb: got %b expected 01", bus.FwdB); end
        step();
        @(negedge clk);
        checks++; if (bus.FwdA !== 2'b10) begin errors++; $display("FAIL b2b_fwda_mem: got %b expected 10", bus.FwdA); end
        step();
        idle();
        repeat (4) step();
    endtask

    task automatic test_flush_and_reset();
        drive(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        push_wb(5'd7);
        step();
        drive(1'b1, 1'b1, 1'b1, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b1, 1'b0, 5'd9, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", bus.Stall); end
        step();
        idle();
        @(negedge clk);
        checks++; if (bus.StallCount !== 16'(exp_stall_cnt)) begin errors++; $display("FAIL flush_count: got %0d expected %0d", bus.StallCount, exp_stall_cnt); end
        repeat (4) step();

        drive(1'b1, 1'b1, 1'b0, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        push_wb(5'd10);
        step();
        drive(1'b1, 1'b1, 1'b0, 5'd11, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        push_wb(5'd11);
        step();
        idle();
        step();
        checks++; if (bus.WbRegWrt !== 1'b1 || bus.WbRd !== 5'd10) begin errors++; $display("FAIL pre_reset_wb: got WbRegWrt=%b WbRd=%0d expected 1/10", bus.WbRegWrt, bus.WbRd); end
        // Pending writes die with the reset.
        sb.delete();
        reset = 1'b0;
        #1;
        checks++; if (bus.WbRegWrt !== 1'b0) begin errors++; $display("FAIL midrun_reset_wb: got %b expected 0", bus.WbRegWrt); end
        checks++; if (bus.StallCount !== 16'd0) begin errors++; $display("FAIL midrun_reset_count: got %0d expected 0", bus.StallCount); end
        exp_stall_cnt = 0;
        repeat (2) step();
        reset = 1'b1;
        repeat (4) begin
            step();
            checks++; if (bus.WbRegWrt !== 1'b0) begin errors++; $display("FAIL post_midrun_reset_wb: got %b expected 0", bus.WbRegWrt); end
        end
    endtask

    initial begin
        test_reset();
        test_forward_chain();
        test_load_use();
        test_zero_reg();
        test_back_to_back();
        test_flush_and_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending writes expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
